// File: rtl/valu_pkg.sv
// Shared types for the vector ALU execute stage.
// Opcode and FSM state encodings plus lane addressing helper.
package valu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b011,
    OP_DIV = 3'b100,
    OP_CMP = 3'b101,
    OP_NOP = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    DONE
  } state_e;

  function automatic int unsigned lane_sel(
    input int unsigned idx,
    input int unsigned w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/valu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle.
// done and quotient are valid together in the final iteration cycle.
module valu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsr;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] q_n;

  always_comb begin
    trial = {rem, q[WIDTH-1]};
    sub   = trial - {1'b0, dsr};
    ge    = (trial >= {1'b0, dsr});
    rem_n = ge ? sub[WIDTH-1:0] : trial[WIDTH-1:0];
    q_n   = {q[WIDTH-2:0], ge};
  end

  assign done     = run && (cnt == CW'(WIDTH - 1));
  assign quotient = q_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      rem <= '0;
      q   <= '0;
      dsr <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      rem <= '0;
      q   <= dividend;
      dsr <= divisor;
    end else if (run) begin
      rem <= rem_n;
      q   <= q_n;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/vector_alu_exec.sv
// Vector ALU execute stage: one lane per step, iterative DIV.
// Define VALU_SAT_EN for saturating ADD/SUB/MUL.
module vector_alu_exec
  import valu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             alu_control,
  input  logic                   src_a,
  input  logic [LANES*WIDTH-1:0] vec_a,
  input  logic [LANES*WIDTH-1:0] vec_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic                   wb_en,
  output logic                   flag_eq,
  output logic                   flag_lt,
  output logic                   flag_div0,
  output logic                   flag_illegal,
  output logic                   busy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_e                 state;
  alu_op_e                op;
  logic [LW-1:0]          lane;
  logic [LANES*WIDTH-1:0] opa;
  logic [LANES*WIDTH-1:0] opb;
  logic                   div_act;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [WIDTH-1:0] mul_r;
  logic [WIDTH-1:0] lane_res;
  logic             eq;
  logic             lt;
  logic             last;
  logic             step;
  logic             b_zero;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_q;

  logic is_ar;
  logic is_cmp;
  logic is_div;
  logic is_nop;
  logic is_ill;

`ifdef VALU_SAT_EN
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
`endif

  assign a      = opa[lane_sel(32'(lane), WIDTH) +: WIDTH];
  assign b      = opb[lane_sel(32'(lane), WIDTH) +: WIDTH];
  assign eq     = (a == b);
  assign lt     = (a < b);
  assign b_zero = (b == '0);
  assign last   = (lane == LW'(LANES - 1));
  assign busy   = (state != IDLE);

  always_comb begin
`ifdef VALU_SAT_EN
    sum   = {1'b0, a} + {1'b0, b};
    prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    add_r = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    sub_r = lt ? '0 : a - b;
    mul_r = (|prod[2*WIDTH-1:WIDTH]) ? '1 : prod[WIDTH-1:0];
`else
    add_r = a + b;
    sub_r = a - b;
    mul_r = a * b;
`endif
  end

  always_comb begin
    lane_res = a - b;
    case (op)
      OP_ADD:  lane_res = add_r;
      OP_SUB:  lane_res = sub_r;
      OP_MUL:  lane_res = mul_r;
      default: lane_res = a - b;
    endcase
  end

  always_comb begin
    is_ar  = (alu_control == 3'b000) ||
             (alu_control == 3'b001) ||
             (alu_control == 3'b011);
    is_cmp = (alu_control == 3'b101);
    is_div = (alu_control == 3'b100);
    is_nop = (alu_control == 3'b111);
    is_ill = (alu_control == 3'b010) ||
             (alu_control == 3'b110);
  end

  // A zero divisor bypasses the divider entirely for that lane
  assign div_start = (state == DIV) && !div_act && !b_zero;

  always_comb begin
    step = 1'b0;
    if (state == EXEC) step = 1'b1;
    if (state == DIV) begin
      step = div_act ? div_done : b_zero;
    end
  end

  valu_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op           <= OP_NOP;
      lane         <= '0;
      opa          <= '0;
      opb          <= '0;
      div_act      <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      result       <= '0;
      wb_en        <= 1'b0;
      flag_eq      <= 1'b0;
      flag_lt      <= 1'b0;
      flag_div0    <= 1'b0;
      flag_illegal <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            opa          <= src_a ? '0 : vec_a;
            opb          <= vec_b;
            lane         <= '0;
            result       <= '0;
            in_ready     <= 1'b0;
            flag_eq      <= 1'b0;
            flag_lt      <= 1'b0;
            flag_div0    <= 1'b0;
            flag_illegal <= 1'b0;
            unique case (1'b1)
              is_ar: begin
                op    <= alu_op_e'(alu_control);
                wb_en <= 1'b1;
                state <= EXEC;
              end
              is_cmp: begin
                op    <= OP_CMP;
                wb_en <= 1'b0;
                state <= EXEC;
              end
              is_div: begin
                op    <= OP_DIV;
                wb_en <= 1'b1;
                state <= DIV;
              end
              is_nop: begin
                op    <= OP_NOP;
                wb_en <= 1'b0;
                state <= DONE;
              end
              is_ill: begin
                op           <= OP_NOP;
                wb_en        <= 1'b0;
                flag_illegal <= 1'b1;
                state        <= DONE;
              end
            endcase
          end
        end
        EXEC: begin
          result[lane_sel(32'(lane), WIDTH) +: WIDTH] <= lane_res;
          if (op == OP_CMP) begin
            flag_eq <= (lane == '0) ? eq : (flag_eq & eq);
            flag_lt <= flag_lt | lt;
          end
        end
        DIV: begin
          if (!div_act) begin
            if (b_zero) begin
              result[lane_sel(32'(lane), WIDTH) +: WIDTH] <= '1;
              flag_div0 <= 1'b1;
            end else begin
              div_act <= 1'b1;
            end
          end else if (div_done) begin
            result[lane_sel(32'(lane), WIDTH) +: WIDTH] <= div_q;
            div_act <= 1'b0;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
      if (step) begin
        if (last) begin
          lane  <= '0;
          state <= DONE;
        end else begin
          lane <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_alu_exec.sv
// Directed bench for vector_alu_exec (LANES=4, WIDTH=8).
// Table of operations plus hold, reset-abort and illegal sequences.
module tb_vector_alu_exec;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int VW    = LANES * WIDTH;

  typedef struct {
    logic [2:0]    op;
    logic          sa;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [VW-1:0] res;
    logic          wb;
    logic [3:0]    fl;
    int            lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_control;
  logic          src_a;
  logic [VW-1:0] vec_a;
  logic [VW-1:0] vec_b;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] result;
  logic          wb_en;
  logic          flag_eq;
  logic          flag_lt;
  logic          flag_div0;
  logic          flag_illegal;
  logic          busy;

  int checks = 0;
  int errors = 0;

  vec_t tbl[10];

  always #5 clk = ~clk;

  vector_alu_exec #(
    .LANES(LANES),
    .WIDTH(WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_control  (alu_control),
    .src_a        (src_a),
    .vec_a        (vec_a),
    .vec_b        (vec_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .wb_en        (wb_en),
    .flag_eq      (flag_eq),
    .flag_lt      (flag_lt),
    .flag_div0    (flag_div0),
    .flag_illegal (flag_illegal),
    .busy         (busy)
  );

  function automatic logic [VW-1:0] pk(
    input int l0, input int l1, input int l2, input int l3
  );
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic vec_t mk(
    input logic [2:0] op, input logic sa,
    input logic [VW-1:0] a, input logic [VW-1:0] b,
    input logic [VW-1:0] res, input logic wb,
    input logic [3:0] fl, input int lat
  );
    vec_t v;
    v.op = op; v.sa = sa; v.a = a; v.b = b;
    v.res = res; v.wb = wb; v.fl = fl; v.lat = lat;
    return v;
  endfunction

  task automatic chk(
    input string n, input logic [63:0] act, input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 200);
  endtask

  task automatic run_op(input vec_t v);
    int cyc;
    in_valid    = 1'b1;
    alu_control = v.op;
    src_a       = v.sa;
    vec_a       = v.a;
    vec_b       = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(cyc);
    chk("latency", 64'(cyc), 64'(v.lat));
    chk("result", 64'(result), 64'(v.res));
    chk("wb_en", 64'(wb_en), 64'(v.wb));
    chk("flags",
        64'({flag_eq, flag_lt, flag_div0, flag_illegal}),
        64'(v.fl));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release", 64'({out_valid, in_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    vec_t v;
    int cyc;
    logic bad;
    logic [VW-1:0] held;

    tbl[0] = mk(3'b000, 0, pk(10,20,250,0), pk(5,5,10,0),
`ifdef VALU_SAT_EN
                pk(15,25,255,0),
`else
                pk(15,25,4,0),
`endif
                1, 4'b0000, 5);
    tbl[1] = mk(3'b001, 1, pk(9,9,9,9), pk(1,2,3,4),
`ifdef VALU_SAT_EN
                pk(0,0,0,0),
`else
                pk(255,254,253,252),
`endif
                1, 4'b0000, 5);
    tbl[2] = mk(3'b101, 0, pk(7,7,7,7), pk(7,7,7,7),
                pk(0,0,0,0), 0, 4'b1000, 5);
    tbl[3] = mk(3'b101, 0, pk(7,7,7,7), pk(7,8,7,7),
                pk(0,255,0,0), 0, 4'b0100, 5);
    tbl[4] = mk(3'b100, 0, pk(100,9,255,50), pk(7,3,0,50),
                pk(14,3,255,1), 1, 4'b0010, 29);
    tbl[5] = mk(3'b011, 0, pk(3,16,200,0), pk(5,16,2,9),
`ifdef VALU_SAT_EN
                pk(15,255,255,0),
`else
                pk(15,0,144,0),
`endif
                1, 4'b0000, 5);
    tbl[6] = mk(3'b111, 0, pk(1,2,3,4), pk(5,6,7,8),
                pk(0,0,0,0), 0, 4'b0000, 1);
    tbl[7] = mk(3'b110, 0, pk(1,2,3,4), pk(5,6,7,8),
                pk(0,0,0,0), 0, 4'b0001, 1);
    tbl[8] = mk(3'b100, 0, pk(200,17,1,255), pk(3,17,2,1),
                pk(66,1,0,255), 1, 4'b0000, 37);
    tbl[9] = mk(3'b101, 0, pk(9,0,0,0), pk(3,0,0,0),
                pk(6,0,0,0), 0, 4'b0000, 5);

    rst = 1'b1;
    in_valid = 1'b0;
    alu_control = 3'b000;
    src_a = 1'b0;
    vec_a = '0;
    vec_b = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_hs", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    chk("reset_res", 64'(result), 64'(0));
    chk("reset_flags",
        64'({wb_en, flag_eq, flag_lt, flag_div0, flag_illegal}),
        64'(0));

    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    // Hold in DONE with ignored requests
    in_valid = 1'b1;
    alu_control = tbl[0].op;
    src_a = 1'b0;
    vec_a = tbl[0].a;
    vec_b = tbl[0].b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(cyc);
    chk("hold_lat", 64'(cyc), 64'(5));
    held = result;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      alu_control = 3'b001;
      vec_a = pk(k, 1, 2, 3);
      vec_b = pk(9, 9, 9, 9);
      @(posedge clk); #1;
      if (result !== tbl[0].res || !out_valid || in_ready || !wb_en)
        bad = 1'b1;
    end
    in_valid = 1'b0;
    chk("hold_stable", 64'(bad), 64'(0));
    chk("hold_value", 64'(held), 64'(tbl[0].res));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release", 64'({out_valid, in_ready, busy}), 64'(3'b010));
    chk("hold_keep", 64'(result), 64'(tbl[0].res));

    // Reset during DIV lane 2
    in_valid = 1'b1;
    alu_control = 3'b100;
    vec_a = tbl[8].a;
    vec_b = tbl[8].b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_hs", 64'({out_valid, in_ready, busy}), 64'(3'b010));
    chk("abort_res", 64'(result), 64'(0));
    rst = 1'b0;

    v = mk(3'b010, 0, pk(1,1,1,1), pk(2,2,2,2),
           pk(0,0,0,0), 0, 4'b0001, 1);
    run_op(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
